// File: rtl/aca_pkg.sv
// Shared definitions for the variable-latency almost-correct adder.
//   aca_state_e      : controller state encoding (IDLE, EVAL, CORR, HOLD)
//   aca_params_legal : elaboration-time legality check of WIDTH/WINDOW/ERR_CNT_W
package aca_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_CORR = 2'd2,
      ST_HOLD = 2'd3
   } aca_state_e;

   function automatic bit aca_params_legal(input int width, input int window,
                                           input int cnt_w);
      return (width >= 4) && (width <= 64) &&
             (window >= 2) && (window <= width - 1) &&
             (cnt_w >= 1);
   endfunction

endpackage

// File: rtl/aca_spec_core.sv
// Combinational speculative adder with conservative error detection.
//   a, b, cin  : operands and carry-in
//   spec_sum   : speculative sum (carries above WINDOW seen through a WINDOW-bit window)
//   spec_cout  : speculative carry into bit WIDTH
//   err        : 1 when some WINDOW-bit propagate run exists starting at bit >= 1,
//                i.e. the speculative result may be wrong
module aca_spec_core #(
   parameter int WIDTH  = 16,
   parameter int WINDOW = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] spec_sum,
   output logic             spec_cout,
   output logic             err
);

   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g;
   logic [WIDTH:0]   w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   always_comb begin
      logic [WIDTH:0] c;
      logic           t;
      c    = '0;
      t    = 1'b0;
      c[0] = cin;
      // Low carries ripple exactly from cin.
      for (int i = 1; i <= WINDOW; i++) begin
         c[i] = w_g[i-1] | (w_p[i-1] & c[i-1]);
      end
      // Upper carries only look at the WINDOW bits below them, carry-in 0.
      for (int i = WINDOW + 1; i <= WIDTH; i++) begin
         t = 1'b0;
         for (int j = i - WINDOW; j < i; j++) begin
            t = w_g[j] | (w_p[j] & t);
         end
         c[i] = t;
      end
      w_c = c;
   end

   always_comb begin
      err = 1'b0;
      for (int k = 1; k <= WIDTH - WINDOW; k++) begin
         if (&w_p[k +: WINDOW]) err = 1'b1;
      end
   end

   assign spec_sum  = w_p ^ w_c[WIDTH-1:0];
   assign spec_cout = w_c[WIDTH];

endmodule

// File: rtl/aca_vl_adder.sv
// Variable-latency almost-correct adder: speculative result in one evaluation
// cycle, exact recomputation one cycle later when the error detector fires.
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready           : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready         : result handshake (out_sum, out_cout, out_corrected)
//   err_cnt                     : saturating recovery-event count, only when
//                                 ACA_ERR_CNT_EN is defined
module aca_vl_adder
   import aca_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int WINDOW    = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic                 out_cout,
`ifdef ACA_ERR_CNT_EN
   output logic [ERR_CNT_W-1:0] err_cnt,
`endif
   output logic                 out_corrected
);

   if (!aca_params_legal(WIDTH, WINDOW, ERR_CNT_W)) begin : g_bad_params
      $error("aca_vl_adder: illegal WIDTH/WINDOW/ERR_CNT_W combination");
   end

   aca_state_e       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cin;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_corr;
   logic             r_valid;

   logic [WIDTH-1:0] w_spec_sum;
   logic             w_spec_cout;
   logic             w_err;
   logic [WIDTH:0]   w_exact;

   aca_spec_core #(
      .WIDTH  (WIDTH),
      .WINDOW (WINDOW)
   ) u_spec (
      .a         (r_a),
      .b         (r_b),
      .cin       (r_cin),
      .spec_sum  (w_spec_sum),
      .spec_cout (w_spec_cout),
      .err       (w_err)
   );

   assign w_exact = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};

   // Forced low during reset so nothing is handed over on a reset edge.
   assign in_ready = rst_n & ((r_state == ST_IDLE) ||
                              ((r_state == ST_HOLD) && out_ready));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_corr  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_cin   <= in_cin;
                  r_state <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (!w_err) begin
                  r_sum   <= w_spec_sum;
                  r_cout  <= w_spec_cout;
                  r_corr  <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= ST_HOLD;
               end else begin
                  r_state <= ST_CORR;
               end
            end
            ST_CORR: begin
               r_sum   <= w_exact[WIDTH-1:0];
               r_cout  <= w_exact[WIDTH];
               r_corr  <= 1'b1;
               r_valid <= 1'b1;
               r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  if (in_valid) begin
                     r_a     <= in_a;
                     r_b     <= in_b;
                     r_cin   <= in_cin;
                     r_state <= ST_EVAL;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ACA_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] r_err_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if ((r_state == ST_EVAL) && w_err && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign err_cnt = r_err_cnt;
`endif

   assign out_valid     = r_valid;
   assign out_sum       = r_sum;
   assign out_cout      = r_cout;
   assign out_corrected = r_corr;

endmodule

// File: tb/tb_aca_vl_adder.sv
// Self-checking bench for aca_vl_adder at WIDTH=8, WINDOW=4.
// Reference model: the result is always the exact sum a+b+cin; out_corrected
// equals the window-run error predicate; latency counts the accept cycle as 1.
module tb_aca_vl_adder;

   localparam int W   = 8;
   localparam int WIN = 4;
   localparam int CW  = 16;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_corrected;
`ifdef ACA_ERR_CNT_EN
   logic [CW-1:0] err_cnt;
   int            exp_cnt;
`endif

   int total;
   int bad;

   aca_vl_adder #(
      .WIDTH     (W),
      .WINDOW    (WIN),
      .ERR_CNT_W (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_cin        (in_cin),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sum       (out_sum),
      .out_cout      (out_cout),
`ifdef ACA_ERR_CNT_EN
      .err_cnt       (err_cnt),
`endif
      .out_corrected (out_corrected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_total(input int a, input int b, input int ci);
      return a + b + ci;
   endfunction

   function automatic bit m_err(input int a, input int b);
      int p;
      int mask;
      p    = a ^ b;
      mask = (1 << WIN) - 1;
      for (int k = 1; k <= W - WIN; k++) begin
         if (((p >> k) & mask) == mask) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Single operation from IDLE: accept, wait for the result, consume it.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, output int lat,
                         output logic [W-1:0] s, output logic co,
                         output logic cr, output logic ok);
      int n;
      ok        = 1'b1;
      out_ready = 1'b0;
      n         = 0;
      #1;
      while (!in_ready && n < 10) begin
         tick();
         n++;
      end
      if (!in_ready) ok = 1'b0;
      in_a     = a;
      in_b     = b;
      in_cin   = ci;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_cin   = 1'($urandom);
      lat      = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      if (!out_valid) ok = 1'b0;
      s  = out_sum;
      co = out_cout;
      cr = out_corrected;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
`ifdef ACA_ERR_CNT_EN
      if (m_err(int'(a), int'(b))) exp_cnt++;
`endif
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'b1;
      out_ready = 1'b0;
      tick();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_sum !== '0) begin bad++; $display("FAIL reset_sum got=%h exp=00", out_sum); end
      total++; if (out_cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
      total++; if (out_corrected !== 1'b0) begin bad++; $display("FAIL reset_corr got=%b exp=0", out_corrected); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
`ifdef ACA_ERR_CNT_EN
      exp_cnt = 0;
      total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [4];
      logic [W-1:0] vb [4];
      int           lat;
      logic [W-1:0] s;
      logic         co, cr, ok;
      int           t;
      bit           e;
      va[0] = 8'h0F; vb[0] = 8'h01;
      va[1] = 8'h1F; vb[1] = 8'h01;
      va[2] = 8'hFF; vb[2] = 8'h01;
      va[3] = 8'h1E; vb[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
`ifdef ACA_ERR_CNT_EN
         int c0;
         c0 = int'(err_cnt);
`endif
         run_op(va[i], vb[i], 1'b0, lat, s, co, cr, ok);
         t = m_total(int'(va[i]), int'(vb[i]), 0);
         e = m_err(int'(va[i]), int'(vb[i]));
         total++; if (!ok) begin bad++; $display("FAIL dir%0d_timeout a=%h b=%h", i, va[i], vb[i]); end
         total++; if (s !== W'(t)) begin bad++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s, W'(t)); end
         total++; if (co !== 1'(t >> W)) begin bad++; $display("FAIL dir%0d_cout got=%b exp=%b", i, co, 1'(t >> W)); end
         total++; if (cr !== e) begin bad++; $display("FAIL dir%0d_corr got=%b exp=%b", i, cr, e); end
         total++; if (lat != (e ? 3 : 2)) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, e ? 3 : 2); end
`ifdef ACA_ERR_CNT_EN
         total++; if (int'(err_cnt) != c0 + (e ? 1 : 0)) begin bad++; $display("FAIL dir%0d_err_cnt got=%0d exp=%0d", i, err_cnt, c0 + (e ? 1 : 0)); end
`endif
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] s0;
      int           n;
      out_ready = 1'b0;
      in_a      = 8'h1E;
      in_b      = 8'h00;
      in_cin    = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_a = 8'h55;
      in_b = 8'hAA;
      n    = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      total++; if (!out_valid) begin bad++; $display("FAIL stall_timeout got=%b exp=1", out_valid); end
      s0 = out_sum;
      total++; if (s0 !== 8'h1E || out_corrected !== 1'b1) begin bad++; $display("FAIL stall_result got=%h/%b exp=1e/1", s0, out_corrected); end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || out_sum !== 8'h1E || out_corrected !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold%0d got v=%b s=%h c=%b r=%b exp v=1 s=1e c=1 r=0",
                     i, out_valid, out_sum, out_corrected, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", out_valid); end
`ifdef ACA_ERR_CNT_EN
      exp_cnt++;
`endif
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qa [3];
      logic [W-1:0] qb [3];
      logic         qc [3];
      int           idx, got, t;
      logic         acc, v_ov;
      qa[0] = 8'h3C; qb[0] = 8'h05; qc[0] = 1'b1;
      qa[1] = 8'h1F; qb[1] = 8'h01; qc[1] = 1'b0;
      qa[2] = W'($urandom); qb[2] = W'($urandom); qc[2] = 1'($urandom);
      idx       = 0;
      got       = 0;
      out_ready = 1'b1;
      in_a      = qa[0];
      in_b      = qb[0];
      in_cin    = qc[0];
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
         #1;
         acc  = in_ready && in_valid;
         v_ov = out_valid;
         if (v_ov) begin
            t = m_total(int'(qa[got]), int'(qb[got]), int'(qc[got]));
            total++;
            if (out_sum !== W'(t) || out_cout !== 1'(t >> W) ||
                out_corrected !== m_err(int'(qa[got]), int'(qb[got]))) begin
               bad++;
               $display("FAIL b2b_result%0d got=%h/%b/%b exp=%h/%b/%b", got, out_sum, out_cout,
                        out_corrected, W'(t), 1'(t >> W), m_err(int'(qa[got]), int'(qb[got])));
            end
            got++;
         end
         if (acc && idx > 0) begin
            total++;
            if (!v_ov) begin bad++; $display("FAIL b2b_accept%0d got out_valid=%b exp=1", idx, v_ov); end
         end
         tick();
         if (acc) begin
            idx++;
            if (idx < 3) begin
               in_a   = qa[idx];
               in_b   = qb[idx];
               in_cin = qc[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      total++; if (got != 3 || idx != 3) begin bad++; $display("FAIL b2b_count got=%0d/%0d exp=3/3", got, idx); end
      in_valid  = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b exp=0", out_valid); end
      out_ready = 1'b0;
`ifdef ACA_ERR_CNT_EN
      for (int i = 0; i < 3; i++) if (m_err(int'(qa[i]), int'(qb[i]))) exp_cnt++;
`endif
   endtask

   task automatic test_random();
      int           lat, t;
      logic [W-1:0] a, b, s;
      logic         ci, co, cr, ok;
      bit           e;
      for (int i = 0; i < 30; i++) begin
         a  = W'($urandom);
         b  = (i % 2 == 0) ? (~a ^ W'(1 << $urandom_range(0, W-1))) : W'($urandom);
         ci = 1'($urandom);
         run_op(a, b, ci, lat, s, co, cr, ok);
         t = m_total(int'(a), int'(b), int'(ci));
         e = m_err(int'(a), int'(b));
         total++;
         if (!ok || s !== W'(t) || co !== 1'(t >> W) || cr !== e || lat != (e ? 3 : 2)) begin
            bad++;
            $display("FAIL rand%0d a=%h b=%h ci=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=%0d",
                     i, a, b, ci, s, co, cr, lat, W'(t), 1'(t >> W), e, e ? 3 : 2);
         end
      end
`ifdef ACA_ERR_CNT_EN
      total++; if (int'(err_cnt) != exp_cnt) begin bad++; $display("FAIL rand_err_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
`endif
   endtask

   task automatic test_reset_in_corr();
      int           lat;
      logic [W-1:0] s;
      logic         co, cr, ok;
      out_ready = 1'b0;
      in_a      = 8'hFF;
      in_b      = 8'h01;
      in_cin    = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstcorr_ready_low got=%b exp=0", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_corrected !== 1'b0) begin
         bad++;
         $display("FAIL rstcorr_outputs got v=%b s=%h c=%b k=%b exp all 0", out_valid, out_sum, out_cout, out_corrected);
      end
`ifdef ACA_ERR_CNT_EN
      exp_cnt = 0;
      total++; if (err_cnt !== '0) begin bad++; $display("FAIL rstcorr_err_cnt got=%0d exp=0", err_cnt); end
`endif
      rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rstcorr_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
      run_op(8'h1F, 8'h01, 1'b0, lat, s, co, cr, ok);
      total++;
      if (!ok || s !== 8'h20 || co !== 1'b0 || cr !== 1'b1 || lat != 3) begin
         bad++;
         $display("FAIL rstcorr_first_op got=%h/%b/%b lat=%0d exp=20/0/1 lat=3", s, co, cr, lat);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
`ifdef ACA_ERR_CNT_EN
      exp_cnt   = 0;
`endif
      test_reset();
      test_directed();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_in_corr();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aca_vl_adder.md
Name: aca_vl_adder

Overview:
- Parametrised, variable-latency successor to the 8-bit almost-correct adder.
- A WIDTH-bit speculative adder computes each carry from a sliding window of WINDOW lower bits.
- A conservative error detector flags operands where the speculative result may be wrong; those results are recomputed exactly one cycle later.
- Sits between operand producers and consumers in the approximate-arithmetic datapath, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/sum width in bits; legal range 4..64.
- WINDOW, 4, speculative carry window in bits; legal range 2..WIDTH-1. Any other value is an elaboration error.
- ERR_CNT_W, 16, width of the recovery-event counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  sum.
- out_cout  out  1  carry-out (carry into bit WIDTH).
- out_corrected  out  1  result came from the exact recovery path.
- err_cnt  out  ERR_CNT_W  recovery-event count; present only with ACA_ERR_CNT_EN.

Behaviour:
- Per-bit signals: P[i]=a^b, G[i]=a&b, sum bit S[i]=P[i]^C[i].
- Speculative carries:
  - For i<=WINDOW, C[i] is exact, including cin.
  - For WINDOW<i<=WIDTH, C[i] is the group generate of bits i-WINDOW..i-1 with carry-in 0.
- Error flag err = OR over k=1..WIDTH-WINDOW of (P[k+WINDOW-1:k] all ones).
  - err is conservative: err=0 guarantees the speculative sum and cout are exact.
  - False positives are allowed and are recovered normally.
- Exact path: full-width carry chain from cin, evaluated only in state CORR.
- State machine (one operation in flight):
  - IDLE: in_ready=1. On in_valid, capture a/b/cin into operand registers and go to EVAL.
  - EVAL: in_ready=0.
    - If err=0: register speculative sum/cout, set out_corrected=0 and out_valid=1, go to HOLD.
    - If err=1: go to CORR.
  - CORR: in_ready=0. Register exact sum/cout, set out_corrected=1 and out_valid=1, go to HOLD.
  - HOLD: out_valid=1 and out_sum/out_cout/out_corrected are stable. in_ready=out_ready.
    - If out_ready and in_valid: capture the new operands, clear out_valid, go to EVAL (back-to-back).
    - If out_ready and !in_valid: clear out_valid, go to IDLE.
    - If !out_ready: stay in HOLD.
- Latency from accept edge to out_valid=1: 2 cycles when err=0, 3 cycles when err=1.
- Peak throughput: one result per 2 cycles (err=0) or per 3 cycles (err=1).
- Operands are sampled only on the accept edge; changing in_a/in_b later has no effect on the in-flight operation.
- Reset (rst_n=0 at a clock edge, in any state):
  - state=IDLE; out_valid=0, out_sum=0, out_cout=0, out_corrected=0, operand registers=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first edge after release.
  - An in-flight operation is discarded with no output.
- Arithmetic is unsigned modulo 2^WIDTH; out_cout carries the overflow bit.

Optional Feature:
- Macro ACA_ERR_CNT_EN.
- Defined:
  - err_cnt port exists.
  - Increments by 1 on each EVAL->CORR transition and saturates at all-ones.
  - Cleared by reset.
- Undefined: no counter logic and no err_cnt port; all other behaviour identical.

Decomposition:
- Package aca_pkg: state enum (IDLE, EVAL, CORR, HOLD) and the WIDTH/WINDOW legality check function.
- One sub-module, aca_spec_core: purely combinational.
  - Inputs: a, b, cin. Outputs: spec_sum, spec_cout, err.
  - Parametrised by WIDTH and WINDOW.
- The top holds the FSM, the operand/result registers, the exact path and the optional counter.

Test Plan (WIDTH=8, WINDOW=4):
- a=0x0F, b=0x01, cin=0 -> err=0; out_valid 2 cycles after accept; sum=0x10, cout=0, out_corrected=0.
- a=0x1F, b=0x01, cin=0 -> err=1 (run bits1..4); out_valid after 3 cycles; sum=0x20, cout=0, out_corrected=1 (speculative would give 0x00).
- a=0xFF, b=0x01, cin=0 -> corrected path; sum=0x00, cout=1, out_corrected=1. With the macro defined, err_cnt increments by 1.
- False positive a=0x1E, b=0x00 -> sum=0x1E, out_corrected=1. out_ready held low 5 cycles -> out_valid and result stable throughout, in_ready=0.
- Back-to-back: in_valid held high with out_ready=1 over 3 operations -> each accepted on its HOLD-exit edge, no result dropped or duplicated.
- rst_n=0 asserted during CORR -> next edge: IDLE, out_valid=0, all outputs 0; the first accept after release computes correctly.
